ram_1rnw_lvt_core: RTL and testbench
====================================

Name: ram_1RNW_lvt_core

Overview:
- Single-clock RAM with WR_PORT_NB independent write ports and one registered read port. It is the write-side counterpart of the existing N-read/1-write core.
- Built as a Live Value Table (LVT) design. There is one storage bank per write port, and each bank is an instance of ram_NR1W_behav_core. A small LVT array records which bank holds the live value of each address.
- Used wherever several pipeline stages must update a shared table (for example, accumulators and scratch tables) that one consumer reads.

Parameters:
- WIDTH, 32, data width.
- DEPTH, 64, number of words.
- WR_PORT_NB, 2, number of write ports. Must be >= 2.
- HAS_RST, 1'b0, when 1 the reset invalidates every entry.
- RST_VAL, '0, data returned for invalidated entries (WIDTH bits).
- Derived localparams: ADD_W = $clog2(DEPTH), SEL_W = max(1, $clog2(WR_PORT_NB)).

Ports:
- clk  in  1  clock.
- s_rst_n  in  1  synchronous active-low reset.
- wr_en  in  [WR_PORT_NB]  per-port write enable.
- wr_add  in  ADD_W x [WR_PORT_NB]  per-port write address.
- wr_data  in  WIDTH x [WR_PORT_NB]  per-port write data.
- rd_en  in  1  read request.
- rd_add  in  ADD_W  read address.
- rd_data  out  WIDTH  read data, registered.
- rd_avail  out  1  rd_data is valid this cycle.

Behaviour:
- Banks:
  - Bank j is written only by port j, on wr_en[j] at wr_add[j]. The bank's own reset is unused (HAS_RST=0).
  - Bank j is read at rd_add only; RD_PORT_NB=1.
- LVT:
  - DEPTH entries, each SEL_W bits plus, when HAS_RST, 1 valid bit.
  - On a clock edge where wr_en[j] is set: lvt[wr_add[j]] <= j and valid <= 1.
- Write collision (several ports write the same address in one cycle):
  - The highest port index wins; the LVT records that index.
  - The losing banks are still written, but are never selected for that address.
- Read:
  - rd_en sampled at edge t. At edge t+1: rd_data <= bank[lvt[rd_add]][rd_add] and rd_avail <= 1.
  - Latency is exactly 1 cycle, with full throughput (one read per cycle).
  - When rd_en=0: rd_avail <= 0, and rd_data holds its previous value.
- Read/write ordering:
  - A read and a write to the same address at the same edge: the read returns the OLD value (read-before-write).
  - A read issued on the edge after the write returns the new value.
  - This applies to every write port and to the collision winner.
- Reset (HAS_RST=1):
  - While s_rst_n=0, all valid bits clear in one cycle, rd_avail <= 0, and rd_data <= RST_VAL.
  - A read of an invalid entry returns RST_VAL.
  - Writes presented during reset are dropped.
  - Reset mid-operation aborts any pending read: no rd_avail is asserted on the edge after reset deasserts unless rd_en is sampled then.
- Reset (HAS_RST=0):
  - Only rd_avail (<= 0) and rd_data (<= RST_VAL) are reset.
  - RAM contents are undefined until written, and writes during reset still take effect.
- Out-of-range addresses (>= DEPTH when DEPTH is not a power of 2):
  - Writes are ignored.
  - Reads return X-free RST_VAL.
- No combinational path from any input to rd_data or rd_avail.

Decomposition:
- The shared package holds:
  - function lvt_sel_w(int n), returning max(1, clog2(n));
  - typedef-free constants: none beyond that.
- Sub-module: ram_NR1W_behav_core, instantiated WR_PORT_NB times as banks.
- The LVT and the output register stay in this module. The LVT is small, resettable and written by multiple ports, so it is coded as a flop array.

Test Plan (WIDTH=32, DEPTH=64, WR_PORT_NB=3):
- Single write: port1 writes 0xA5A5_0001 at address 5, then rd_en at address 5 on the next cycle -> one cycle later rd_avail=1 and rd_data=0xA5A5_0001.
- Overwrite across ports: port0 writes 0x11 at address 7, and two cycles later port2 writes 0x22 at address 7; read address 7 -> 0x22. Port0 then writes 0x33 at address 7; read -> 0x33.
- Collision: ports 0, 1 and 2 write 0x10, 0x20, 0x30 at address 9 in the same cycle; read address 9 -> 0x30. With port2 idle and ports 0 and 1 colliding -> 0x20.
- Read-before-write: port0 writes 0x55 at address 3 in the same cycle as rd_en at address 3, which previously held 0x44 -> returns 0x44. Back-to-back read next cycle -> 0x55.
- Reset (HAS_RST=1, RST_VAL=0xDEAD_BEEF):
  - Fill addresses 0..63, pulse s_rst_n low for 1 cycle, then read address 12 -> 0xDEAD_BEEF.
  - A write presented during reset is absent afterwards.
  - rd_avail=0 during reset.
- Throughput/random: 2000 cycles of random writes on all ports plus a read every cycle, checked against a scoreboard model (highest index wins, read-before-write) -> zero mismatches, and rd_avail equals rd_en delayed by 1 cycle.

Source files
------------

// File: rtl/ram_1rnw_lvt_core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ram_1rnw_lvt_core_pkg                                      |
// | Description : Shared helpers for the multi-write LVT RAM core.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ram_1rnw_lvt_core_pkg;

  // Width of an LVT bank selector: enough bits to name every write port,
  // and never less than one bit.
  function automatic int lvt_sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_1rnw_lvt_core_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ram_NR1W_behav_core                                        |
// | Description : Behavioural storage bank, one write port and RD_PORT_NB    |
// |               asynchronous read ports. Out-of-range accesses are         |
// |               ignored on write and return RST_VAL on read.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ram_NR1W_behav_core
  import ram_1rnw_lvt_core_pkg::*;
#(
  parameter int                 WIDTH      = 32,
  parameter int                 DEPTH      = 64,
  parameter int                 RD_PORT_NB = 1,
  parameter logic               HAS_RST    = 1'b0,
  parameter logic [WIDTH-1:0]   RST_VAL    = '0,
  localparam int                ADD_W      = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  s_rst_n,
  input  logic                                  wr_en,
  input  logic [ADD_W-1:0]                      wr_add,
  input  logic [WIDTH-1:0]                      wr_data,
  input  logic [RD_PORT_NB-1:0][ADD_W-1:0]      rd_add,
  output logic [RD_PORT_NB-1:0][WIDTH-1:0]      rd_data
);

  localparam logic [ADD_W:0] c_depth = (ADD_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_go;

  // Writes are dropped out of range and, for a resettable bank, during reset.
  assign w_wr_go = wr_en && ({1'b0, wr_add} < c_depth) && (s_rst_n || !HAS_RST);

  // Storage array update.
  always_ff @(posedge clk) begin
    if (w_wr_go) begin
      r_mem[wr_add] <= wr_data;
    end
  end

  generate
    for (genvar i = 0; i < RD_PORT_NB; i++) begin : g_rd
      assign rd_data[i] = ({1'b0, rd_add[i]} < c_depth) ? r_mem[rd_add[i]] : RST_VAL;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ram_1rnw_lvt_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ram_1rnw_lvt_core                                          |
// | Description : WR_PORT_NB-write / 1-read RAM built from one bank per      |
// |               write port plus a Live Value Table naming the bank that    |
// |               holds the newest data for each address. Registered read,   |
// |               read-before-write, highest port index wins a collision.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ram_1rnw_lvt_core
  import ram_1rnw_lvt_core_pkg::*;
#(
  parameter int                 WIDTH      = 32,
  parameter int                 DEPTH      = 64,
  parameter int                 WR_PORT_NB = 2,
  parameter logic               HAS_RST    = 1'b0,
  parameter logic [WIDTH-1:0]   RST_VAL    = '0,
  localparam int                ADD_W      = $clog2(DEPTH),
  localparam int                SEL_W      = lvt_sel_w(WR_PORT_NB)
) (
  input  logic                                  clk,
  input  logic                                  s_rst_n,
  input  logic [WR_PORT_NB-1:0]                 wr_en,
  input  logic [WR_PORT_NB-1:0][ADD_W-1:0]      wr_add,
  input  logic [WR_PORT_NB-1:0][WIDTH-1:0]      wr_data,
  input  logic                                  rd_en,
  input  logic [ADD_W-1:0]                      rd_add,
  output logic [WIDTH-1:0]                      rd_data,
  output logic                                  rd_avail
);

  localparam logic [ADD_W:0] c_depth = (ADD_W+1)'(DEPTH);

  logic [WR_PORT_NB-1:0]               w_wr_go;
  logic [WR_PORT_NB-1:0][WIDTH-1:0]    w_bank_rd;
  logic                                w_wr_allow;
  logic [SEL_W-1:0]                    r_lvt_sel [DEPTH];
  logic [DEPTH-1:0]                    w_lvt_vld;
  logic                                w_rd_in_rng;
  logic [SEL_W-1:0]                    w_rd_sel;
  logic [WIDTH-1:0]                    w_rd_val;

  // A resettable core drops writes while reset is held; otherwise they land.
  assign w_wr_allow = s_rst_n || !HAS_RST;

  generate
    for (genvar j = 0; j < WR_PORT_NB; j++) begin : g_bank
      assign w_wr_go[j] = wr_en[j] && ({1'b0, wr_add[j]} < c_depth) && w_wr_allow;

      // Losing banks of a collision are still written; the LVT just never
      // points at them for that address.
      ram_NR1W_behav_core #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .RD_PORT_NB (1),
        .HAS_RST    (1'b0),
        .RST_VAL    (RST_VAL)
      ) u_bank (
        .clk     (clk),
        .s_rst_n (1'b1),
        .wr_en   (w_wr_go[j]),
        .wr_add  (wr_add[j]),
        .wr_data (wr_data[j]),
        .rd_add  (rd_add),
        .rd_data (w_bank_rd[j])
      );
    end
  endgenerate

  // LVT selector: ports are visited in ascending order so the highest index wins.
  always_ff @(posedge clk) begin
    for (int j = 0; j < WR_PORT_NB; j++) begin
      if (w_wr_go[j]) begin
        r_lvt_sel[wr_add[j]] <= SEL_W'(j);
      end
    end
  end

  generate
    if (HAS_RST) begin : g_vld
      logic [DEPTH-1:0] r_lvt_vld;

      // Valid bits: cleared together by reset, set by any accepted write.
      always_ff @(posedge clk) begin
        if (!s_rst_n) begin
          r_lvt_vld <= '0;
        end else begin
          for (int j = 0; j < WR_PORT_NB; j++) begin
            if (w_wr_go[j]) begin
              r_lvt_vld[wr_add[j]] <= 1'b1;
            end
          end
        end
      end

      assign w_lvt_vld = r_lvt_vld;
    end else begin : g_no_vld
      assign w_lvt_vld = '1;
    end
  endgenerate

  assign w_rd_in_rng = ({1'b0, rd_add} < c_depth);
  assign w_rd_sel    = r_lvt_sel[rd_add];

  // Pick the live bank; invalid or out-of-range addresses read as RST_VAL.
  always_comb begin
    w_rd_val = RST_VAL;
    if (w_rd_in_rng && w_lvt_vld[rd_add]) begin
      for (int j = 0; j < WR_PORT_NB; j++) begin
        if (w_rd_sel == SEL_W'(j)) begin
          w_rd_val = w_bank_rd[j];
        end
      end
    end
  end

  // Output register: sampled at the same edge as any write, hence read-before-write.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      rd_avail <= 1'b0;
      rd_data  <= RST_VAL;
    end else begin
      rd_avail <= rd_en;
      if (rd_en) begin
        rd_data <= w_rd_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_1rnw_lvt_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ram_1rnw_lvt_core                                       |
// | Description : Scoreboard bench for the multi-write LVT RAM core.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ram_1rnw_lvt_core;

  localparam int               WIDTH = 32;
  localparam int               DEPTH = 64;
  localparam int               NP    = 3;
  localparam int               ADD_W = 6;
  localparam logic [WIDTH-1:0] RV    = 32'hDEAD_BEEF;

  logic                         clk = 1'b0;
  logic                         s_rst_n;
  logic [NP-1:0]                wr_en;
  logic [NP-1:0][ADD_W-1:0]     wr_add;
  logic [NP-1:0][WIDTH-1:0]     wr_data;
  logic                         rd_en;
  logic [ADD_W-1:0]             rd_add;
  logic [WIDTH-1:0]             rd_data;
  logic                         rd_avail;

  always #5 clk = ~clk;

  ram_1rnw_lvt_core #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .WR_PORT_NB (NP),
    .HAS_RST    (1'b1),
    .RST_VAL    (RV)
  ) dut (
    .clk      (clk),
    .s_rst_n  (s_rst_n),
    .wr_en    (wr_en),
    .wr_add   (wr_add),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_add   (rd_add),
    .rd_data  (rd_data),
    .rd_avail (rd_avail)
  );

  // Reference model: plain memory image plus "ever written since reset" flags.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_vld [DEPTH];

  logic [WIDTH-1:0] exp_q[$];
  logic             exp_avail = 1'b0;
  logic [WIDTH-1:0] exp_hold  = RV;
  bit               mon_on    = 1'b0;
  int               n_checks  = 0;
  int               n_fail    = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("rd_avail", {31'b0, rd_avail}, {31'b0, exp_avail});
        if (rd_avail === 1'b1 || exp_avail) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_data_unexpected: got %h expected no read at %0t", rd_data, $time);
          end else begin
            chk("rd_data", rd_data, exp_q.pop_front());
          end
        end else begin
          chk("rd_data_hold", rd_data, exp_hold);
        end
      end
    end
  end

  // Apply the current inputs for one clock and update the model.
  task automatic step();
    logic [WIDTH-1:0] v;
    exp_avail = s_rst_n && rd_en;
    if (!s_rst_n) begin
      exp_hold = RV;
      for (int a = 0; a < DEPTH; a++) m_vld[a] = 1'b0;
    end else begin
      if (rd_en) begin
        v = m_vld[rd_add] ? m_mem[rd_add] : RV;
        exp_q.push_back(v);
        exp_hold = v;
      end
      for (int p = 0; p < NP; p++) begin
        if (wr_en[p]) begin
          m_mem[wr_add[p]] = wr_data[p];
          m_vld[wr_add[p]] = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    s_rst_n = 1'b1;
    wr_en   = '0;
    rd_en   = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [WIDTH-1:0] d);
    wr_en[p]   = 1'b1;
    wr_add[p]  = ADD_W'(a);
    wr_data[p] = d;
  endtask

  task automatic rd(input int a);
    rd_en  = 1'b1;
    rd_add = ADD_W'(a);
  endtask

  initial begin
    s_rst_n = 1'b0;
    wr_en   = '0;
    wr_add  = '0;
    wr_data = '0;
    rd_en   = 1'b0;
    rd_add  = '0;
    mon_on  = 1'b1;
    step();                              // reset state
    step();

    wr(1, 5, 32'hA5A5_0001); step();     // single write
    rd(5); step();
    step();

    wr(0, 7, 32'h11); step();            // overwrite across ports
    step();
    wr(2, 7, 32'h22); step();
    rd(7); step();
    wr(0, 7, 32'h33); step();
    rd(7); step();

    wr(0, 9, 32'h10); wr(1, 9, 32'h20); wr(2, 9, 32'h30); step();  // collision
    rd(9); step();
    wr(0, 9, 32'h10); wr(1, 9, 32'h20); step();
    rd(9); step();

    wr(0, 3, 32'h44); step();            // read-before-write
    wr(0, 3, 32'h55); rd(3); step();
    rd(3); step();

    for (int a = 0; a < DEPTH; a++) begin  // fill, then reset
      wr(a % NP, a, $urandom);
      step();
    end
    rd(40); step();
    s_rst_n = 1'b0; wr(0, 20, 32'h1234_5678); rd(12); step();
    rd(12); step();
    rd(20); step();

    for (int c = 0; c < 2000; c++) begin  // random traffic
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          wr(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH-1), $urandom);
        end
      end
      if ($urandom_range(0, 9) != 0) begin
        rd(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH-1));
      end
      step();
    end

    step();
    step();
    mon_on = 1'b0;
    chk("queue_drained", WIDTH'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
